// File: rtl/leaf_rx_demux_if.sv
// Bus bundle for leaf_rx_demux: BFT receive stream, per-channel user handshake and credit return path.
interface leaf_rx_demux_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_IN_PORTS  = 5
);
  logic [PACKET_BITS-1:0]                din_leaf_bft2interface;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
  logic [NUM_IN_PORTS-1:0]               vld_interface2user;
  logic [NUM_IN_PORTS-1:0]               ack_user2interface;
  logic [NUM_IN_PORTS*NUM_LEAF_BITS-1:0] cfg_src_leaf;
  logic [NUM_IN_PORTS*NUM_PORT_BITS-1:0] cfg_src_port;
  logic [PACKET_BITS-1:0]                dout_credit_pkt;
  logic                                  credit_ready;
  logic [NUM_IN_PORTS-1:0]               overflow;
  logic [7:0]                            drop_cnt;

  modport master (
    output din_leaf_bft2interface, ack_user2interface, cfg_src_leaf, cfg_src_port, credit_ready,
    input  dout_leaf_interface2user, vld_interface2user, dout_credit_pkt, overflow, drop_cnt
  );

  modport slave (
    input  din_leaf_bft2interface, ack_user2interface, cfg_src_leaf, cfg_src_port, credit_ready,
    output dout_leaf_interface2user, vld_interface2user, dout_credit_pkt, overflow, drop_cnt
  );
endinterface

// File: rtl/leaf_rx_demux.sv
// Leaf receive demux: routes BFT packets into per-channel FWFT FIFOs and returns round-robin credit packets.
// Defining LEAF_RX_DEST_CHECK_EN additionally drops packets whose leaf field differs from SELF_LEAF.
module leaf_rx_demux #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_IN_PORTS          = 5,
  parameter int FIFO_DEPTH_BITS       = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int SELF_LEAF             = 0
) (
  input logic           clk,
  input logic           reset_n,
  leaf_rx_demux_if.slave bus
);
  localparam int DEPTH    = 1 << FIFO_DEPTH_BITS;
  localparam int PC_W     = $clog2(FREESPACE_UPDATE_SIZE) + 1;
  localparam int CH_W     = NUM_PORT_BITS;
  localparam int LEAF_MSB = PACKET_BITS - 2;
  localparam int PORT_MSB = LEAF_MSB - NUM_LEAF_BITS;
  localparam int RSV_MSB  = PORT_MSB - NUM_PORT_BITS;
  localparam logic [NUM_PORT_BITS:0]   LP_NUM_IN   = (NUM_PORT_BITS+1)'(NUM_IN_PORTS);
  localparam logic [FIFO_DEPTH_BITS:0] LP_DEPTH    = (FIFO_DEPTH_BITS+1)'(DEPTH);
  localparam logic [PC_W-1:0]          LP_POP_LAST = PC_W'(FREESPACE_UPDATE_SIZE - 1);
  localparam logic [CH_W-1:0]          LP_LAST_CH  = CH_W'(NUM_IN_PORTS - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  logic                     w_inValid, w_leafOk, w_portOk, w_accept, w_unused;
  logic [NUM_LEAF_BITS-1:0] w_inLeaf;
  logic [NUM_PORT_BITS-1:0] w_inPort;
  logic [PAYLOAD_BITS-1:0]  w_inPayload;

  logic [PAYLOAD_BITS-1:0]    r_mem     [NUM_IN_PORTS][DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wrPtr   [NUM_IN_PORTS];
  logic [FIFO_DEPTH_BITS-1:0] r_rdPtr   [NUM_IN_PORTS];
  logic [FIFO_DEPTH_BITS:0]   r_count   [NUM_IN_PORTS];
  logic [PC_W-1:0]            r_popCnt  [NUM_IN_PORTS];
  logic [7:0]                 r_pending [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0]    r_overflow;
  logic [7:0]                 r_dropCnt;

  logic [NUM_IN_PORTS-1:0] w_wr, w_ovf, w_pop, w_inc, w_dec, w_vld;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] w_dout;

  state_t                 r_state, w_nextState;
  logic [CH_W-1:0]        r_sel, r_rrPtr, w_pick, w_pickHi, w_pickLo;
  logic                   w_foundHi, w_foundLo, w_found, w_load, w_sendDone;
  logic [PACKET_BITS-1:0] r_creditPkt, w_loadPkt;

  assign w_inValid   = bus.din_leaf_bft2interface[PACKET_BITS-1];
  assign w_inLeaf    = bus.din_leaf_bft2interface[LEAF_MSB -: NUM_LEAF_BITS];
  assign w_inPort    = bus.din_leaf_bft2interface[PORT_MSB -: NUM_PORT_BITS];
  assign w_inPayload = bus.din_leaf_bft2interface[PAYLOAD_BITS-1:0];
  assign w_portOk    = {1'b0, w_inPort} < LP_NUM_IN;

`ifdef LEAF_RX_DEST_CHECK_EN
  assign w_leafOk = (w_inLeaf == NUM_LEAF_BITS'(SELF_LEAF));
  assign w_unused = &{1'b0, bus.din_leaf_bft2interface[RSV_MSB:PAYLOAD_BITS]};
`else
  assign w_leafOk = 1'b1;
  assign w_unused = &{1'b0, bus.din_leaf_bft2interface[RSV_MSB:PAYLOAD_BITS], w_inLeaf};
`endif

  assign w_accept = w_inValid && w_portOk && w_leafOk;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot for the write.
  always_comb begin
    w_wr  = '0;
    w_ovf = '0;
    w_pop = '0;
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (w_accept && (w_inPort == CH_W'(i))) begin
        if (r_count[i] == LP_DEPTH) w_ovf[i] = 1'b1;
        else                        w_wr[i]  = 1'b1;
      end
      w_pop[i] = bus.ack_user2interface[i] && (r_count[i] != '0);
      w_inc[i] = w_pop[i] && (r_popCnt[i] == LP_POP_LAST);
      w_dec[i] = w_sendDone && (r_sel == CH_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        r_wrPtr[i]   <= '0;
        r_rdPtr[i]   <= '0;
        r_count[i]   <= '0;
        r_popCnt[i]  <= '0;
        r_pending[i] <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (w_wr[i])  r_wrPtr[i] <= r_wrPtr[i] + 1'b1;
        if (w_pop[i]) r_rdPtr[i] <= r_rdPtr[i] + 1'b1;
        if (w_wr[i] && !w_pop[i])      r_count[i] <= r_count[i] + 1'b1;
        else if (!w_wr[i] && w_pop[i]) r_count[i] <= r_count[i] - 1'b1;
        if (w_inc[i])      r_popCnt[i] <= '0;
        else if (w_pop[i]) r_popCnt[i] <= r_popCnt[i] + 1'b1;
        if (w_inc[i] && !w_dec[i] && (r_pending[i] != 8'hFF)) r_pending[i] <= r_pending[i] + 8'd1;
        else if (!w_inc[i] && w_dec[i])                        r_pending[i] <= r_pending[i] - 8'd1;
        if (w_ovf[i]) r_overflow[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (w_wr[i]) r_mem[i][r_wrPtr[i]] <= w_inPayload;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 r_dropCnt <= '0;
    else if (w_inValid && !w_accept && (r_dropCnt != 8'hFF)) r_dropCnt <= r_dropCnt + 8'd1;
  end

  // Heads are gated by vld so the user sees zero data on empty channels.
  always_comb begin
    w_vld  = '0;
    w_dout = '0;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      w_vld[i] = (r_count[i] != '0);
      if (w_vld[i]) w_dout[i*PAYLOAD_BITS +: PAYLOAD_BITS] = r_mem[i][r_rdPtr[i]];
    end
  end

  assign bus.vld_interface2user       = w_vld;
  assign bus.dout_leaf_interface2user = w_dout;
  assign bus.dout_credit_pkt          = r_creditPkt;
  assign bus.overflow                 = r_overflow;
  assign bus.drop_cnt                 = r_dropCnt;

  // Descending scans keep the lowest index in each half: at/after rr_ptr first, then wrapped.
  always_comb begin
    w_foundHi = 1'b0;
    w_foundLo = 1'b0;
    w_pickHi  = '0;
    w_pickLo  = '0;
    for (int i = NUM_IN_PORTS - 1; i >= 0; i--) begin
      if (r_pending[i] != 8'd0) begin
        if (CH_W'(i) >= r_rrPtr) begin
          w_foundHi = 1'b1;
          w_pickHi  = CH_W'(i);
        end else begin
          w_foundLo = 1'b1;
          w_pickLo  = CH_W'(i);
        end
      end
    end
    w_found = w_foundHi || w_foundLo;
    w_pick  = w_foundHi ? w_pickHi : w_pickLo;
  end

  always_comb begin
    w_loadPkt = '0;
    w_loadPkt[PACKET_BITS-1] = 1'b1;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (w_pick == CH_W'(i)) begin
        w_loadPkt[LEAF_MSB -: NUM_LEAF_BITS] = bus.cfg_src_leaf[i*NUM_LEAF_BITS +: NUM_LEAF_BITS];
        w_loadPkt[PORT_MSB -: NUM_PORT_BITS] = bus.cfg_src_port[i*NUM_PORT_BITS +: NUM_PORT_BITS];
      end
    end
    w_loadPkt[CH_W-1:0] = w_pick;
    w_loadPkt[31:16]    = 16'(FREESPACE_UPDATE_SIZE);
  end

  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_sendDone  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_load      = 1'b1;
          w_nextState = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.credit_ready) begin
          w_sendDone  = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_creditPkt <= '0;
      r_sel       <= '0;
      r_rrPtr     <= '0;
    end else if (w_load) begin
      r_creditPkt <= w_loadPkt;
      r_sel       <= w_pick;
    end else if (w_sendDone) begin
      r_creditPkt <= '0;
      r_rrPtr     <= (r_sel == LP_LAST_CH) ? '0 : r_sel + 1'b1;
    end
  end
endmodule

// File: tb/tb_leaf_rx_demux.sv
// Directed self-checking bench for leaf_rx_demux: routing, FIFO limits, drops and credit return.
module tb_leaf_rx_demux;
  localparam int PB  = 49;
  localparam int PLB = 32;
  localparam int N   = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [PLB-1:0] slices [N];
  logic [PB-1:0]  captured;
  int             seen;

  always #5 clk = ~clk;

  leaf_rx_demux_if bus ();

  leaf_rx_demux dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always_comb begin
    for (int i = 0; i < N; i++) slices[i] = bus.dout_leaf_interface2user[i*PLB +: PLB];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PB-1:0] mkPkt(input logic [4:0] leaf, input logic [3:0] port, input logic [31:0] payload);
    return {1'b1, leaf, port, 7'd0, payload};
  endfunction

  function automatic logic [PB-1:0] mkCredit(input logic [4:0] leaf, input logic [3:0] port, input logic [3:0] ch);
    return {1'b1, leaf, port, 7'd0, 16'd64, 12'd0, ch};
  endfunction

  // One clock of receive traffic and acks; inputs return to idle afterwards.
  task automatic applyStimulus(input logic [PB-1:0] din, input logic [N-1:0] ack);
    bus.din_leaf_bft2interface = din;
    bus.ack_user2interface     = ack;
    tick();
    bus.din_leaf_bft2interface = '0;
    bus.ack_user2interface     = '0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    tick();
    tick();
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic fillChannel(input logic [3:0] port, input int words);
    for (int k = 0; k < words; k++) applyStimulus(mkPkt(5'd0, port, 32'(k)), '0);
  endtask

  task automatic popChannels(input logic [N-1:0] ack, input int words);
    for (int k = 0; k < words; k++) applyStimulus('0, ack);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.din_leaf_bft2interface = '0;
    bus.ack_user2interface     = '0;
    bus.cfg_src_leaf           = '0;
    bus.cfg_src_port           = '0;
    bus.credit_ready           = 1'b0;

    #12;
    checkOutput("rst_vld", bus.vld_interface2user, 5'b0);
    checkOutput("rst_credit", bus.dout_credit_pkt, '0);
    checkOutput("rst_ovf", bus.overflow, 5'b0);
    checkOutput("rst_drop", bus.drop_cnt, 8'd0);
    checkOutput("rst_dout", bus.dout_leaf_interface2user, '0);
    reset_n = 1'b1;
    tick();

    $display("[TB] single packet to port 2");
    applyStimulus(mkPkt(5'd0, 4'd2, 32'hDEADBEEF), '0);
    checkOutput("p2_vld", bus.vld_interface2user, 5'b00100);
    checkOutput("p2_data", slices[2], 32'hDEADBEEF);
    applyStimulus('0, 5'b00100);
    checkOutput("p2_popped", bus.vld_interface2user, 5'b0);

    $display("[TB] simultaneous write and pop on port 4");
    applyStimulus(mkPkt(5'd0, 4'd4, 32'hAAAA0001), '0);
    applyStimulus(mkPkt(5'd0, 4'd4, 32'hBBBB0002), 5'b10000);
    checkOutput("wp_vld", bus.vld_interface2user, 5'b10000);
    checkOutput("wp_head", slices[4], 32'hBBBB0002);
    applyStimulus('0, 5'b10000);
    checkOutput("wp_empty", bus.vld_interface2user, 5'b0);

    $display("[TB] invalid packet ignored");
    applyStimulus(mkPkt(5'd0, 4'd1, 32'h1) & ~(49'd1 << 48), '0);
    checkOutput("inv_vld", bus.vld_interface2user, 5'b0);
    checkOutput("inv_drop", bus.drop_cnt, 8'd0);

    $display("[TB] overflow on port 0");
    doReset();
    fillChannel(4'd0, 129);
    checkOutput("ovf_flag", bus.overflow, 5'b00001);
    checkOutput("ovf_vld", bus.vld_interface2user, 5'b00001);
    checkOutput("ovf_head", slices[0], 32'd0);
    applyStimulus(mkPkt(5'd0, 4'd0, 32'd999), 5'b00001);
    checkOutput("ovf_sticky", bus.overflow, 5'b00001);
    for (int k = 1; k < 128; k++) begin
      checkOutput($sformatf("drain_%0d", k), slices[0], 32'(k));
      applyStimulus('0, 5'b00001);
    end
    checkOutput("drain_empty", bus.vld_interface2user, 5'b0);
    checkOutput("ovf_nodrop", bus.drop_cnt, 8'd0);

    $display("[TB] bad port and bad leaf drops");
    doReset();
    applyStimulus(mkPkt(5'd0, 4'd7, 32'h1234), '0);
    checkOutput("bp7_vld", bus.vld_interface2user, 5'b0);
    checkOutput("bp7_drop", bus.drop_cnt, 8'd1);
    applyStimulus(mkPkt(5'd0, 4'd5, 32'h1234), '0);
    checkOutput("bp5_drop", bus.drop_cnt, 8'd2);
    applyStimulus(mkPkt(5'd3, 4'd1, 32'h55), '0);
`ifdef LEAF_RX_DEST_CHECK_EN
    checkOutput("leaf_vld", bus.vld_interface2user, 5'b0);
    checkOutput("leaf_drop", bus.drop_cnt, 8'd3);
`else
    checkOutput("leaf_vld", bus.vld_interface2user, 5'b00010);
    checkOutput("leaf_data", slices[1], 32'h55);
    checkOutput("leaf_drop", bus.drop_cnt, 8'd2);
`endif
    for (int k = 0; k < 300; k++) applyStimulus(mkPkt(5'd0, 4'd15, 32'h0), '0);
    checkOutput("drop_sat", bus.drop_cnt, 8'd255);

    $display("[TB] credit packet for channel 1");
    doReset();
    bus.cfg_src_leaf[1*5 +: 5] = 5'd4;
    bus.cfg_src_port[1*4 +: 4] = 4'd9;
    bus.credit_ready = 1'b1;
    fillChannel(4'd1, 64);
    popChannels(5'b00010, 64);
    seen = 0;
    captured = '0;
    for (int k = 0; k < 10; k++) begin
      if (bus.dout_credit_pkt[PB-1]) begin
        seen++;
        captured = bus.dout_credit_pkt;
      end
      tick();
    end
    checkOutput("cr1_count", 64'(seen), 64'd1);
    checkOutput("cr1_pkt", captured, mkCredit(5'd4, 4'd9, 4'd1));

    $display("[TB] round-robin credits with back-pressure");
    doReset();
    bus.credit_ready = 1'b0;
    bus.cfg_src_leaf[0*5 +: 5] = 5'd1;
    bus.cfg_src_port[0*4 +: 4] = 4'd2;
    bus.cfg_src_leaf[3*5 +: 5] = 5'd6;
    bus.cfg_src_port[3*4 +: 4] = 4'd11;
    fillChannel(4'd0, 64);
    fillChannel(4'd3, 64);
    popChannels(5'b01001, 64);
    checkOutput("rr_idle", bus.dout_credit_pkt, '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("rr_hold_%0d", k), bus.dout_credit_pkt, mkCredit(5'd1, 4'd2, 4'd0));
    end
    bus.credit_ready = 1'b1;
    tick();
    checkOutput("rr_sent0", bus.dout_credit_pkt, '0);
    tick();
    checkOutput("rr_ch3", bus.dout_credit_pkt, mkCredit(5'd6, 4'd11, 4'd3));
    tick();
    checkOutput("rr_sent3", bus.dout_credit_pkt, '0);
    tick();
    checkOutput("rr_none", bus.dout_credit_pkt, '0);
    bus.credit_ready = 1'b0;

    $display("[TB] reset during SEND");
    doReset();
    fillChannel(4'd1, 64);
    popChannels(5'b00010, 64);
    fillChannel(4'd2, 10);
    fillChannel(4'd3, 129);
    applyStimulus(mkPkt(5'd0, 4'd9, 32'h0), '0);
    checkOutput("mid_send", bus.dout_credit_pkt[PB-1], 1'b1);
    checkOutput("mid_vld", bus.vld_interface2user, 5'b01100);
    checkOutput("mid_ovf", bus.overflow, 5'b01000);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_credit", bus.dout_credit_pkt, '0);
    checkOutput("async_vld", bus.vld_interface2user, 5'b0);
    checkOutput("async_drop", bus.drop_cnt, 8'd0);
    tick();
    #2 reset_n = 1'b1;
    tick();
    checkOutput("post_vld", bus.vld_interface2user, 5'b0);
    checkOutput("post_ovf", bus.overflow, 5'b0);
    checkOutput("post_credit", bus.dout_credit_pkt, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/leaf_rx_demux.md
Name: leaf_rx_demux

Overview:
- Parametrised receive-side port demultiplexer for a leaf, generalising the fixed-count leaf shells (i1o1 … i5o1) to NUM_IN_PORTS channels.
- Takes the packet stream from the BFT, decodes the port field, and buffers each payload in a per-channel FIFO.
- Presents each channel to the user kernel with a vld/ack handshake.
- Generates round-robin free-space (credit) packets back toward each channel's source as words are consumed.

Parameters:
- PACKET_BITS, 49, width of a BFT packet.
- PAYLOAD_BITS, 32, width of the user data word.
- NUM_LEAF_BITS, 5, width of the leaf address field.
- NUM_PORT_BITS, 4, width of the port field.
- NUM_IN_PORTS, 5, number of user input channels (1..2^NUM_PORT_BITS).
- FIFO_DEPTH_BITS, 7, log2 of per-channel FIFO depth (128 words).
- FREESPACE_UPDATE_SIZE, 64, pops per channel that earn one credit packet (power of two, ≤ depth).
- SELF_LEAF, 0, this leaf's address; used only by the optional feature.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous reset, active low.
- din_leaf_bft2interface  in  PACKET_BITS  incoming packet. Fields, MSB down: [MSB] valid; leaf (NUM_LEAF_BITS); port (NUM_PORT_BITS); reserved; payload in [PAYLOAD_BITS-1:0].
- dout_leaf_interface2user  out  NUM_IN_PORTS*PAYLOAD_BITS  per-channel FIFO head; channel i occupies slice i.
- vld_interface2user  out  NUM_IN_PORTS  channel i FIFO non-empty.
- ack_user2interface  in  NUM_IN_PORTS  pop request for channel i.
- cfg_src_leaf  in  NUM_IN_PORTS*NUM_LEAF_BITS  credit destination leaf per channel.
- cfg_src_port  in  NUM_IN_PORTS*NUM_PORT_BITS  credit destination port per channel.
- dout_credit_pkt  out  PACKET_BITS  credit packet; MSB is valid.
- credit_ready  in  1  downstream accepts dout_credit_pkt this cycle.
- overflow  out  NUM_IN_PORTS  sticky: a packet was dropped because channel i was full.
- drop_cnt  out  8  saturating count of packets discarded for a bad port (or, with the optional feature, a bad leaf).

Behaviour:
- Reset (asynchronous, effective immediately):
  - FIFO pointers and counts, pop counters, pending-credit counters, round-robin pointer, overflow and drop_cnt cleared.
  - Credit FSM forced to IDLE.
  - All outputs 0, including dout_credit_pkt valid.
- Receive path:
  - A packet is processed only when din valid=1. Port value p < NUM_IN_PORTS selects channel p.
  - p ≥ NUM_IN_PORTS: packet dropped, drop_cnt += 1, saturating at 255.
- Write rule:
  - A packet is accepted when the channel's count < 2^FIFO_DEPTH_BITS, sampled at the start of the cycle.
  - A pop in the same cycle does not make room for that cycle's write.
  - If the channel is full, the packet is dropped and overflow[p] is set; it stays set until reset.
- Latency: a packet accepted at edge t gives vld=1 and its payload on dout after edge t (one cycle). The FIFO is first-word-fall-through.
- Pop:
  - ack_user2interface[i] with vld_interface2user[i]=1 pops one word at the edge.
  - ack with vld=0 is ignored.
  - A simultaneous write and pop on a non-full FIFO leaves count unchanged and preserves order.
- Pointers wrap modulo depth; count is FIFO_DEPTH_BITS+1 bits wide.
- Credit accounting:
  - Each pop increments the channel's pop counter.
  - When the counter reaches FREESPACE_UPDATE_SIZE it returns to 0 and the pending-credit counter increments (saturating at 255).
  - An increment and a decrement of pending in the same cycle leave it unchanged.
- Credit FSM:
  - IDLE: if any pending > 0, pick the first channel at or after rr_ptr with pending > 0. Load dout_credit_pkt:
    - valid=1
    - leaf = cfg_src_leaf[i], port = cfg_src_port[i]
    - reserved = 0
    - payload = {zeros, channel index in low NUM_PORT_BITS+... bits: payload[NUM_PORT_BITS-1:0] = i, payload[31:16] = FREESPACE_UPDATE_SIZE}
    - Go to SEND.
  - SEND: hold the packet stable. When credit_ready=1: decrement pending[i], set rr_ptr = i+1 mod NUM_IN_PORTS, clear valid, return to IDLE.
- Throughput: at most one credit packet every 2 cycles.
- cfg_* inputs are sampled only when the packet is loaded in IDLE.

Optional Feature:
- Macro: LEAF_RX_DEST_CHECK_EN.
- Defined: packets whose leaf field ≠ SELF_LEAF are dropped and counted in drop_cnt; the port check still applies.
- Undefined: the leaf field is ignored, and drop_cnt counts only bad-port drops.

Test Plan:
- Reset, then one packet {valid=1, leaf=0, port=2, payload=0xDEADBEEF} → vld[2]=1 one cycle later, slice 2 = 0xDEADBEEF, other vld=0; ack[2] for one cycle → vld[2]=0.
- 129 back-to-back packets to port 0 with no ack → 128 words stored, overflow[0]=1; draining with ack yields payloads 0..127 in order.
- Packet with port=7 (NUM_IN_PORTS=5) → no vld change, drop_cnt=1. With LEAF_RX_DEST_CHECK_EN and leaf=3, SELF_LEAF=0 → drop_cnt increments, no write.
- 64 pops on channel 1 with cfg_src_leaf[1]=4, cfg_src_port[1]=9, credit_ready=1 → one credit packet: valid, leaf=4, port=9, payload[3:0]=1, payload[31:16]=64.
- Earn credits on channels 0 and 3 together while credit_ready=0 for 5 cycles → packet for channel 0 held stable; on ready, channel 0 is sent, then channel 3.
- Assert reset_n=0 mid-SEND with 10 words queued → dout_credit_pkt=0 and vld=0 immediately; after release, all FIFOs are empty and overflow=0.
